// File: rtl/serial_addersubtractor_pkg.sv
// Shared constants and elaboration helpers for the digit-serial adder/subtractor.
package serial_addersubtractor_pkg;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
      return width / digit;
   endfunction

   // Counter needs at least one bit even when a single digit covers the word.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_addersubtractor_digit_adder.sv
// DIGIT-bit combinational ripple adder built from full-adder cells; also exposes the carry into its top bit.
module digit_adder #(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_i,
   input  logic [DIGIT-1:0] b_i,
   input  logic             cin_i,
   output logic [DIGIT-1:0] sum_o,
   output logic             cout_o,
   output logic             cmsb_o
);

   logic [DIGIT:0] c;

   assign c[0] = cin_i;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end

   assign cout_o = c[DIGIT];
   assign cmsb_o = c[DIGIT-1];

endmodule

// File: rtl/serial_addersubtractor.sv
// Digit-serial two's-complement adder/subtractor: one DIGIT-bit ripple stage per cycle, LSB digit first.
module serial_addersubtractor
   import serial_addersubtractor_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             s,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned NUM_DIGITS = num_digits(WIDTH, DIGIT);
   localparam int unsigned CW         = cnt_width(NUM_DIGITS);
   localparam logic [CW-1:0] LAST     = CW'(NUM_DIGITS - 1);

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;

   logic [DIGIT-1:0] dig_sum;
   logic             dig_cout, dig_cmsb;

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .a_i    (a_q[DIGIT-1:0]),
      .b_i    (b_q[DIGIT-1:0]),
      .cin_i  (carry_q),
      .sum_o  (dig_sum),
      .cout_o (dig_cout),
      .cmsb_o (dig_cmsb)
   );

   // Operands shift right and the result fills from the top, so the active digit is always at bit 0.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      out_d   = out_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         if (start) begin
            a_d     = in1;
            b_d     = in2 ^ {WIDTH{s}};
            carry_d = s;
            cnt_d   = '0;
            state_d = RUN;
         end
      end else begin
         a_d     = a_q >> DIGIT;
         b_d     = b_q >> DIGIT;
         res_d   = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
         carry_d = dig_cout;
         cnt_d   = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            out_d   = res_d;
            cout_d  = dig_cout;
            ovf_d   = dig_cmsb ^ dig_cout;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         out_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         out_q   <= out_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign busy     = (state_q == RUN);
   assign done     = done_q;
   assign out      = out_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addersubtractor.sv
// Scoreboard bench: directed tests on the DIGIT=4 instance, random sweep on DIGIT=1/16/8 instances.
module tb_serial_addersubtractor;

   typedef struct packed {
      logic [15:0] out;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic        start4 = 1'b0, s4 = 1'b0;
   logic [15:0] in1_4 = '0, in2_4 = '0;
   logic        busy4, done4, cout4, ovf4;
   logic [15:0] out4;

   logic        start_sw = 1'b0, s_sw = 1'b0;
   logic [15:0] a_sw = '0, b_sw = '0;
   logic        busy1, done1, cout1, ovf1, busy16, done16, cout16, ovf16, busy8, done8, cout8, ovf8;
   logic [15:0] out1, out16, out8;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t q4[$];
   exp_t q_sw[$];

   always #5 clk = ~clk;

   serial_addersubtractor #(.WIDTH(16), .DIGIT(4)) u4 (
      .clk(clk), .reset(reset), .start(start4), .in1(in1_4), .in2(in2_4), .s(s4),
      .busy(busy4), .done(done4), .out(out4), .cout(cout4), .overflow(ovf4));
   serial_addersubtractor #(.WIDTH(16), .DIGIT(1)) u1 (
      .clk(clk), .reset(reset), .start(start_sw), .in1(a_sw), .in2(b_sw), .s(s_sw),
      .busy(busy1), .done(done1), .out(out1), .cout(cout1), .overflow(ovf1));
   serial_addersubtractor #(.WIDTH(16), .DIGIT(16)) u16 (
      .clk(clk), .reset(reset), .start(start_sw), .in1(a_sw), .in2(b_sw), .s(s_sw),
      .busy(busy16), .done(done16), .out(out16), .cout(cout16), .overflow(ovf16));
   serial_addersubtractor #(.WIDTH(16), .DIGIT(8)) u8 (
      .clk(clk), .reset(reset), .start(start_sw), .in1(a_sw), .in2(b_sw), .s(s_sw),
      .busy(busy8), .done(done8), .out(out8), .cout(cout8), .overflow(ovf8));

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic m);
      exp_t        r;
      logic [15:0] bb;
      logic [16:0] f;
      bb     = b ^ {16{m}};
      f      = {1'b0, a} + {1'b0, bb} + 17'(m);
      r.out  = f[15:0];
      r.cout = f[16];
      r.ovf  = (a[15] == bb[15]) && (f[15] != a[15]);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Waits from the current negedge sample for done4; returns samples elapsed and busy samples seen.
   task automatic wait4(input string tag, output int lat, output int busycnt);
      exp_t e;
      lat = -1;
      busycnt = 0;
      for (int m = 0; m < 40; m++) begin
         if (done4) begin
            lat = m;
            if (q4.size() == 0) begin
               chk({tag, "_unexpected_done"}, 32'd1, 32'd0);
            end else begin
               e = q4.pop_front();
               chk({tag, "_result"}, {13'd0, busy4, out4, cout4, ovf4}, {13'd0, 1'b0, e.out, e.cout, e.ovf});
            end
            break;
         end
         if (busy4) busycnt++;
         @(negedge clk);
      end
   endtask

   task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic m, input string tag);
      int lat, bc;
      @(negedge clk);
      in1_4 = a; in2_4 = b; s4 = m; start4 = 1'b1;
      q4.push_back(model(a, b, m));
      @(negedge clk);
      start4 = 1'b0;
      wait4(tag, lat, bc);
      chk({tag, "_latency"}, lat, 4);
      chk({tag, "_busy_cycles"}, bc, 4);
      @(negedge clk);
      chk({tag, "_done_pulse"}, {31'd0, done4}, 32'd0);
   endtask

   task automatic op_sweep(input logic [15:0] a, input logic [15:0] b, input logic m);
      exp_t e;
      int   l1, l16, l8;
      @(negedge clk);
      a_sw = a; b_sw = b; s_sw = m; start_sw = 1'b1;
      q_sw.push_back(model(a, b, m));
      @(negedge clk);
      start_sw = 1'b0;
      e = q_sw[0];
      l1 = -1; l16 = -1; l8 = -1;
      for (int k = 0; k < 40 && (l1 < 0 || l16 < 0 || l8 < 0); k++) begin
         if (done1 && l1 < 0) begin
            l1 = k;
            chk("sweep_d1", {15'd0, out1, cout1, ovf1}, {15'd0, e.out, e.cout, e.ovf});
         end
         if (done16 && l16 < 0) begin
            l16 = k;
            chk("sweep_d16", {15'd0, out16, cout16, ovf16}, {15'd0, e.out, e.cout, e.ovf});
         end
         if (done8 && l8 < 0) begin
            l8 = k;
            chk("sweep_d8", {15'd0, out8, cout8, ovf8}, {15'd0, e.out, e.cout, e.ovf});
         end
         @(negedge clk);
      end
      void'(q_sw.pop_front());
      chk("sweep_d1_latency", l1, 16);
      chk("sweep_d16_latency", l16, 1);
      chk("sweep_d8_latency", l8, 2);
   endtask

   initial begin
      int   lat, bc, lat2;
      logic seen;
      exp_t e;

      #3;
      chk("reset_state", {13'd0, busy4, done4, out4, cout4, ovf4}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      op4(16'h1234, 16'h4321, 1'b0, "add");
      op4(16'h0005, 16'h0007, 1'b1, "sub_borrow");
      op4(16'h0007, 16'h0005, 1'b1, "sub_noborrow");
      op4(16'h7FFF, 16'h0001, 1'b0, "ovf_pos");
      op4(16'hFFFF, 16'h0001, 1'b0, "wrap");
      op4(16'h8000, 16'h0001, 1'b1, "ovf_neg");

      // Spec-given values cross-checked against the model
      e = model(16'h1234, 16'h4321, 1'b0);
      chk("spec_add", {14'd0, e.out, e.cout, e.ovf}, {14'd0, 16'h5555, 1'b0, 1'b0});
      e = model(16'h8000, 16'h0001, 1'b1);
      chk("spec_ovf_neg", {14'd0, e.out, e.ovf}, {14'd0, 16'h7FFF, 1'b1});

      // Handshake: start held high, operands changed during RUN, start held in the done cycle
      @(negedge clk);
      in1_4 = 16'h1111; in2_4 = 16'h2222; s4 = 1'b0; start4 = 1'b1;
      q4.push_back(model(16'h1111, 16'h2222, 1'b0));
      @(negedge clk);
      in1_4 = 16'hAAAA; in2_4 = 16'hAAAA;
      wait4("hold_first", lat, bc);
      chk("hold_first_latency", lat, 4);
      q4.push_back(model(16'hAAAA, 16'hAAAA, 1'b0));
      @(negedge clk);
      start4 = 1'b0;
      chk("hold_no_double_done", {31'd0, done4}, 32'd0);
      chk("hold_second_busy", {31'd0, busy4}, 32'd1);
      wait4("hold_second", lat2, bc);
      chk("hold_done_spacing", lat2 + 1, 5);
      @(negedge clk);
      chk("hold_second_pulse", {31'd0, done4}, 32'd0);

      // Reset mid-operation
      in1_4 = 16'h0F0F; in2_4 = 16'h0101; s4 = 1'b0; start4 = 1'b1;
      q4.push_back(model(16'h0F0F, 16'h0101, 1'b0));
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_outputs", {13'd0, busy4, done4, out4, cout4, ovf4}, 32'd0);
      q4.delete();
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done4) seen = 1'b1;
      end
      chk("abort_no_done", {31'd0, seen}, 32'd0);
      op4(16'h4000, 16'h3FFF, 1'b1, "after_abort");

      for (int i = 0; i < 200; i++) begin
         op_sweep(16'($urandom), 16'($urandom), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/serial_addersubtractor.md
Name: serial_addersubtractor

Overview:
- Multi-cycle, digit-serial two's-complement adder/subtractor, parametrised in operand width and digit width.
- Processes DIGIT bits per cycle, LSB digit first, through one DIGIT-bit ripple stage, with carry held in a register between cycles.
- Start/done handshake; results are held stable until the next accepted start.
- Trades latency for area against the fully combinational ripple adders in the arithmetic library.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- s  input  1  mode; 0 = A+B, 1 = A-B.
- busy  output  1  high while an operation is in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- out  output  WIDTH  result, A+B or A-B mod 2^WIDTH.
- cout  output  1  carry out of the MSB; for subtraction, 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, out, cout, overflow all 0; internal operand, carry, count and result registers cleared.
- NUM_DIGITS = WIDTH/DIGIT.
- IDLE:
  - On an edge with start=1: latch A=in1, B'=in2 XOR {WIDTH{s}}, carry=s, count=0; go to RUN.
  - On the same edge: busy goes to 1 and done goes to 0.
  - out, cout and overflow keep their previous values until completion.
- RUN, each edge:
  - Compute digit[count] = A_d + B'_d + carry over DIGIT bits.
  - Write it into the internal result register, update carry, and increment count.
  - On the edge that processes digit NUM_DIGITS-1:
    - out <= full result, cout <= final carry, overflow <= carry_in_msb XOR final carry.
    - done <= 1, busy <= 0, state <= IDLE.
- Latency: start accepted at edge k; result and done are valid after edge k+NUM_DIGITS.
  - Example: NUM_DIGITS=4 gives done 4 cycles after acceptance.
  - Degenerate case DIGIT=WIDTH: one cycle.
- done is high for exactly one cycle; it deasserts on the next edge unless a new completion occurs.
- start while busy=1 is ignored; operand and mode changes during RUN have no effect.
- start asserted in the done cycle is accepted, since the state is IDLE. This gives back-to-back throughput of one operation per NUM_DIGITS+1 cycles.
- carry_in_msb is the carry into bit WIDTH-1, taken from inside the final digit's ripple chain. It is not the digit-level carry.
- Reset asserted mid-RUN aborts the operation: all outputs return to 0 and no done is issued.
- Arithmetic is modulo 2^WIDTH; no saturation.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=0, RUN=1;
  - the NUM_DIGITS derivation and a count-width constant, clog2(NUM_DIGITS), minimum 1.
- One natural sub-module, digit_adder:
  - parametrised DIGIT-bit combinational ripple built from full-adder cells;
  - outputs the sum, the carry out, and the carry into its top bit (used for overflow).
- The top level contains only the FSM, counter, operand and result registers.

Test Plan (WIDTH=16, DIGIT=4):
- Add: in1=0x1234, in2=0x4321, s=0, start pulse -> done exactly 4 cycles later; out=0x5555, cout=0, overflow=0; busy high for those 4 cycles.
- Subtract with borrow: in1=0x0005, in2=0x0007, s=1 -> out=0xFFFE, cout=0, overflow=0. Then 0x0007-0x0005 -> out=0x0002, cout=1.
- Overflow and wrap:
  - 0x7FFF+0x0001 -> out=0x8000, overflow=1, cout=0.
  - 0xFFFF+0x0001 -> out=0x0000, cout=1, overflow=0.
  - 0x8000-0x0001 -> out=0x7FFF, overflow=1.
- Handshake: start held high and operands changed to 0xAAAA during RUN -> the original result is produced. start held in the done cycle -> second operation accepted and its done arrives 5 cycles after the first done. done is never high for 2 consecutive cycles.
- Reset mid-operation: assert reset 2 cycles after start -> busy, done, out, cout and overflow are 0 immediately. No done follows. A new operation afterwards computes correctly.
- Parameter sweep: DIGIT=1, 16 and 8 with a random 200-vector comparison against an A±B model; latency is NUM_DIGITS in every case.
